// File: rtl/axi4lite_reg_slice_if.sv
// -----------------------------------------------------------------------------
// axi4lite_reg_slice_if
// AXI4-Lite bundle (AW, W, B, AR, R) used on both sides of axi4lite_reg_slice.
//   master modport : drives AW/W/AR payload+valid and B/R ready
//   slave modport  : drives AW/W/AR ready and B/R payload+valid
// Parameters: ADDR_WIDTH (AW/AR address), DATA_WIDTH (W/R data, strobe = /8).
// -----------------------------------------------------------------------------
interface axi4lite_reg_slice_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi4lite_reg_slice.sv
// -----------------------------------------------------------------------------
// axi4lite_reg_slice
// Full-throughput AXI4-Lite register slice. Every channel goes through an
// independent 2-entry skid buffer (main + skid register) so that no
// combinational path crosses the slice in either direction; valid/payload
// come from the main register and ready is a flop equal to !skid_valid.
//
// Ports:
//   clk : single clock, rising edge
//   rst : synchronous active-high reset, empties every buffer
//   s   : slave-side bundle toward the CPU controller
//   m   : master-side bundle toward the interconnect
//
// Optional feature macro: AXIL_SLICE_OUTSTANDING_EN
//   When defined, rd/wr outstanding counters (limit MAX_OUTSTANDING) hold
//   m.arvalid / m.awvalid low while the limit is reached. When undefined
//   there is no limit.
// -----------------------------------------------------------------------------

// One channel: EMPTY -> ONE -> FULL skid buffer with registered ready.
// out_en masks the presented valid; the beat stays held in main meanwhile.
module axi4lite_reg_slice_skid #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  // bit0 = main valid, bit1 = skid valid
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] main_s;
  logic [WIDTH-1:0] skid_r;
  logic [WIDTH-1:0] skid_s;
  logic             ready_r;
  logic             in_hs_s;
  logic             out_hs_s;

  assign in_ready  = ready_r;
  assign out_valid = (state_r != ST_EMPTY) & out_en;
  assign out_data  = main_r;
  assign in_hs_s   = in_valid & ready_r;
  assign out_hs_s  = out_valid & out_ready;

  // Next-state and datapath selection for the skid buffer.
  always_comb begin
    state_s = state_r;
    main_s  = main_r;
    skid_s  = skid_r;
    case (state_r)
      ST_EMPTY: begin
        if (in_hs_s) begin
          main_s  = in_data;
          state_s = ST_ONE;
        end else begin
          state_s = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (in_hs_s && out_hs_s) begin
          main_s  = in_data;
          state_s = ST_ONE;
        end else if (in_hs_s) begin
          // Receiver stalled: park the new beat, ready drops next cycle.
          skid_s  = in_data;
          state_s = ST_FULL;
        end else if (out_hs_s) begin
          state_s = ST_EMPTY;
        end else begin
          state_s = ST_ONE;
        end
      end
      ST_FULL: begin
        if (out_hs_s) begin
          main_s  = skid_r;
          state_s = ST_ONE;
        end else begin
          state_s = ST_FULL;
        end
      end
      default: begin
        state_s = ST_EMPTY;
      end
    endcase
  end

  // State, payload and registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_EMPTY;
      main_r  <= {WIDTH{1'b0}};
      skid_r  <= {WIDTH{1'b0}};
      ready_r <= 1'b0;
    end else begin
      state_r <= state_s;
      main_r  <= main_s;
      skid_r  <= skid_s;
      ready_r <= (state_s != ST_FULL);
    end
  end
endmodule

module axi4lite_reg_slice #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  axi4lite_reg_slice_if.slave  s,
  axi4lite_reg_slice_if.master m
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int AX_W       = ADDR_WIDTH + 3;
  localparam int W_W        = DATA_WIDTH + STRB_WIDTH;
  localparam int R_W        = DATA_WIDTH + 2;

  logic [AX_W-1:0] aw_data_s;
  logic [W_W-1:0]  w_data_s;
  logic [1:0]      b_data_s;
  logic [AX_W-1:0] ar_data_s;
  logic [R_W-1:0]  r_data_s;
  logic            aw_en_s;
  logic            ar_en_s;

`ifdef AXIL_SLICE_OUTSTANDING_EN
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0] rd_cnt_r;
  logic [CNT_W-1:0] wr_cnt_r;
  logic             rd_inc_s;
  logic             rd_dec_s;
  logic             wr_inc_s;
  logic             wr_dec_s;

  assign rd_inc_s = m.arvalid & m.arready;
  assign rd_dec_s = s.rvalid & s.rready;
  assign wr_inc_s = m.awvalid & m.awready;
  assign wr_dec_s = s.bvalid & s.bready;
  // Counters are registers, so gating never adds an in-to-out path; a valid
  // once shown cannot be withdrawn because the count only rises on its own
  // handshake.
  assign ar_en_s  = (rd_cnt_r != CNT_MAX);
  assign aw_en_s  = (wr_cnt_r != CNT_MAX);

  // Outstanding read counter: AR issue increments, R completion decrements.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_r <= {CNT_W{1'b0}};
    end else if (rd_inc_s && !rd_dec_s) begin
      rd_cnt_r <= rd_cnt_r + CNT_W'(1);
    end else if (!rd_inc_s && rd_dec_s) begin
      rd_cnt_r <= rd_cnt_r - CNT_W'(1);
    end else begin
      rd_cnt_r <= rd_cnt_r;
    end
  end

  // Outstanding write counter: AW issue increments, B completion decrements.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_r <= {CNT_W{1'b0}};
    end else if (wr_inc_s && !wr_dec_s) begin
      wr_cnt_r <= wr_cnt_r + CNT_W'(1);
    end else if (!wr_inc_s && wr_dec_s) begin
      wr_cnt_r <= wr_cnt_r - CNT_W'(1);
    end else begin
      wr_cnt_r <= wr_cnt_r;
    end
  end
`else
  assign ar_en_s = 1'b1;
  assign aw_en_s = 1'b1;
`endif

  axi4lite_reg_slice_skid #(.WIDTH(AX_W)) u_aw (
    .clk(clk), .rst(rst),
    .in_valid(s.awvalid), .in_ready(s.awready), .in_data({s.awprot, s.awaddr}),
    .out_en(aw_en_s), .out_valid(m.awvalid), .out_ready(m.awready), .out_data(aw_data_s)
  );
  assign {m.awprot, m.awaddr} = aw_data_s;

  axi4lite_reg_slice_skid #(.WIDTH(W_W)) u_w (
    .clk(clk), .rst(rst),
    .in_valid(s.wvalid), .in_ready(s.wready), .in_data({s.wstrb, s.wdata}),
    .out_en(1'b1), .out_valid(m.wvalid), .out_ready(m.wready), .out_data(w_data_s)
  );
  assign {m.wstrb, m.wdata} = w_data_s;

  axi4lite_reg_slice_skid #(.WIDTH(2)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(m.bvalid), .in_ready(m.bready), .in_data(m.bresp),
    .out_en(1'b1), .out_valid(s.bvalid), .out_ready(s.bready), .out_data(b_data_s)
  );
  assign s.bresp = b_data_s;

  axi4lite_reg_slice_skid #(.WIDTH(AX_W)) u_ar (
    .clk(clk), .rst(rst),
    .in_valid(s.arvalid), .in_ready(s.arready), .in_data({s.arprot, s.araddr}),
    .out_en(ar_en_s), .out_valid(m.arvalid), .out_ready(m.arready), .out_data(ar_data_s)
  );
  assign {m.arprot, m.araddr} = ar_data_s;

  axi4lite_reg_slice_skid #(.WIDTH(R_W)) u_r (
    .clk(clk), .rst(rst),
    .in_valid(m.rvalid), .in_ready(m.rready), .in_data({m.rresp, m.rdata}),
    .out_en(1'b1), .out_valid(s.rvalid), .out_ready(s.rready), .out_data(r_data_s)
  );
  assign {s.rresp, s.rdata} = r_data_s;
endmodule

// File: tb/tb_axi4lite_reg_slice.sv
// -----------------------------------------------------------------------------
// tb_axi4lite_reg_slice
// Bench for axi4lite_reg_slice. Channels are indexed 0..4 = AW, W, AR, B, R.
// The model keeps one FIFO of in-flight beats per channel: a channel must
// present valid exactly when its FIFO is non-empty (one-cycle latency), the
// head as payload, and ready whenever fewer than two beats are held.
// The bench plays CPU (AW/W/AR sender, B/R receiver) and interconnect
// (B resp = awaddr[3:2], R = {araddr[5:4], ~araddr}).
// -----------------------------------------------------------------------------
module tb_axi4lite_reg_slice;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi4lite_reg_slice_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_if ();
  axi4lite_reg_slice_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_if ();

  axi4lite_reg_slice #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst), .s(s_if), .m(m_if)
  );

  logic        in_v [5];
  logic [63:0] in_p [5];
  logic        out_rdy [5];
  logic        in_r [5];
  logic        out_v [5];
  logic [63:0] out_p [5];

  assign s_if.awvalid = in_v[0];
  assign s_if.awaddr  = in_p[0][31:0];
  assign s_if.awprot  = in_p[0][34:32];
  assign s_if.wvalid  = in_v[1];
  assign s_if.wdata   = in_p[1][31:0];
  assign s_if.wstrb   = in_p[1][35:32];
  assign s_if.arvalid = in_v[2];
  assign s_if.araddr  = in_p[2][31:0];
  assign s_if.arprot  = in_p[2][34:32];
  assign m_if.bvalid  = in_v[3];
  assign m_if.bresp   = in_p[3][1:0];
  assign m_if.rvalid  = in_v[4];
  assign m_if.rdata   = in_p[4][31:0];
  assign m_if.rresp   = in_p[4][33:32];

  assign in_r[0] = s_if.awready;
  assign in_r[1] = s_if.wready;
  assign in_r[2] = s_if.arready;
  assign in_r[3] = m_if.bready;
  assign in_r[4] = m_if.rready;

  assign out_v[0] = m_if.awvalid;
  assign out_p[0] = {29'b0, m_if.awprot, m_if.awaddr};
  assign out_v[1] = m_if.wvalid;
  assign out_p[1] = {28'b0, m_if.wstrb, m_if.wdata};
  assign out_v[2] = m_if.arvalid;
  assign out_p[2] = {29'b0, m_if.arprot, m_if.araddr};
  assign out_v[3] = s_if.bvalid;
  assign out_p[3] = {62'b0, s_if.bresp};
  assign out_v[4] = s_if.rvalid;
  assign out_p[4] = {30'b0, s_if.rresp, s_if.rdata};

  assign m_if.awready = out_rdy[0];
  assign m_if.wready  = out_rdy[1];
  assign m_if.arready = out_rdy[2];
  assign s_if.bready  = out_rdy[3];
  assign s_if.rready  = out_rdy[4];

  int          tests = 0;
  int          fails = 0;
  logic [63:0] src_q [5][$];
  logic [63:0] mq [5][$];
  int          valid_pct [5];
  int          ready_pct [5];
  logic        hs_in_s [5]  = '{default: 1'b0};
  logic        hs_out_s [5] = '{default: 1'b0};
  logic [63:0] hs_out_p [5];
  int          hs_in_cnt [5]  = '{default: 0};
  int          hs_out_cnt [5] = '{default: 0};
  logic        rst_last = 1'b1;
  int          rd_out = 0;
  int          wr_out = 0;
  string       chn [5] = '{"AW", "W", "AR", "B", "R"};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model check and update, away from the active edge.
  always @(negedge clk) begin
    for (int c = 0; c < 5; c++) begin
      logic ev;
      logic er;
      ev = !rst_last && (mq[c].size() > 0);
`ifdef AXIL_SLICE_OUTSTANDING_EN
      if (c == 2 && rd_out >= MAXO) ev = 1'b0;
      if (c == 0 && wr_out >= MAXO) ev = 1'b0;
`endif
      er = !rst_last && (mq[c].size() < 2);
      chk({"valid_", chn[c]}, {63'b0, out_v[c]}, {63'b0, ev});
      chk({"ready_", chn[c]}, {63'b0, in_r[c]}, {63'b0, er});
      if (ev) chk({"payload_", chn[c]}, out_p[c], mq[c][0]);
      if (rst_last) chk({"rst_payload_", chn[c]}, out_p[c], 64'd0);
      hs_in_s[c]  = in_v[c] && in_r[c];
      hs_out_s[c] = out_v[c] && out_rdy[c];
      hs_out_p[c] = out_p[c];
    end
    if (rst) begin
      for (int c = 0; c < 5; c++) begin
        mq[c].delete();
        hs_in_s[c]  = 1'b0;
        hs_out_s[c] = 1'b0;
      end
      rd_out   = 0;
      wr_out   = 0;
      rst_last = 1'b1;
    end else begin
      rst_last = 1'b0;
      for (int c = 0; c < 5; c++) begin
        if (hs_out_s[c]) begin
          hs_out_cnt[c]++;
          if (mq[c].size() > 0) void'(mq[c].pop_front());
        end
        if (hs_in_s[c]) begin
          hs_in_cnt[c]++;
          mq[c].push_back(in_p[c]);
        end
      end
      if (hs_out_s[2]) rd_out++;
      if (hs_out_s[4]) rd_out--;
      if (hs_out_s[0]) wr_out++;
      if (hs_out_s[3]) wr_out--;
    end
  end

  // Advance one cycle and drive all bench-side inputs (AXI-legal senders).
  task automatic cycle();
    @(posedge clk);
    #1;
    for (int c = 0; c < 5; c++) begin
      if (hs_in_s[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
    end
    if (hs_out_s[0]) src_q[3].push_back({62'b0, hs_out_p[0][3:2]});
    if (hs_out_s[2]) src_q[4].push_back({30'b0, hs_out_p[2][5:4], ~hs_out_p[2][31:0]});
    for (int c = 0; c < 5; c++) begin
      if (in_v[c] && !hs_in_s[c]) begin
        in_v[c] = 1'b1;
      end else if (src_q[c].size() > 0 && int'($urandom_range(0, 99)) < valid_pct[c]) begin
        in_v[c] = 1'b1;
        in_p[c] = src_q[c][0];
      end else begin
        in_v[c] = 1'b0;
      end
      out_rdy[c] = (int'($urandom_range(0, 99)) < ready_pct[c]);
    end
  endtask

  task automatic drain(input int limit);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    while (!done && n < limit) begin
      cycle();
      n++;
      done = 1'b1;
      for (int c = 0; c < 5; c++) begin
        if (src_q[c].size() > 0 || mq[c].size() > 0 || in_v[c]) done = 1'b0;
      end
    end
    chk("drain_timeout", {63'b0, done}, 64'd1);
  endtask

  task automatic clear_sources();
    for (int c = 0; c < 5; c++) begin
      src_q[c].delete();
      in_v[c] = 1'b0;
    end
  endtask

  initial begin
    int base;
    int obase;
    bit seen;
    for (int c = 0; c < 5; c++) begin
      in_v[c]      = 1'b0;
      in_p[c]      = 64'd0;
      out_rdy[c]   = 1'b0;
      valid_pct[c] = 100;
      ready_pct[c] = 100;
    end

    // Reset state
    rst = 1'b1;
    repeat (3) cycle();
    chk("reset_s_awready", {63'b0, s_if.awready}, 64'd0);
    chk("reset_m_arvalid", {63'b0, m_if.arvalid}, 64'd0);
    rst = 1'b0;
    cycle();
    chk("post_rst_ready", {59'b0, s_if.awready, s_if.wready, s_if.arready, m_if.bready, m_if.rready}, 64'h1F);

    // Single write
    src_q[0].push_back({29'b0, 3'b000, 32'h1000_0010});
    src_q[1].push_back({28'b0, 4'hF, 32'hDEAD_BEEF});
    cycle();
    cycle();
    chk("wr_m_awvalid", {63'b0, m_if.awvalid}, 64'd1);
    chk("wr_m_awaddr", {32'b0, m_if.awaddr}, 64'h1000_0010);
    chk("wr_m_wvalid", {63'b0, m_if.wvalid}, 64'd1);
    chk("wr_m_wdata", {28'b0, m_if.wstrb, m_if.wdata}, 64'hF_DEAD_BEEF);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle();
      seen = s_if.bvalid;
    end
    chk("wr_s_bvalid", {63'b0, s_if.bvalid}, 64'd1);
    chk("wr_s_bresp", {62'b0, s_if.bresp}, 64'd0);
    drain(50);

    // Streaming reads: 16 beats, no bubbles
    for (int i = 0; i < 16; i++) src_q[2].push_back({32'b0, 32'h2000_0000 + 32'(4 * i)});
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle();
      seen = m_if.arvalid;
    end
    for (int i = 0; i < 16; i++) begin
      chk("stream_m_arvalid", {63'b0, m_if.arvalid}, 64'd1);
      chk("stream_m_araddr", {32'b0, m_if.araddr}, {32'b0, 32'h2000_0000 + 32'(4 * i)});
      cycle();
    end
    drain(100);

    // Backpressure: receiver stalled for 5 cycles
    ready_pct[2] = 0;
    base  = hs_in_cnt[2];
    obase = hs_out_cnt[2];
    for (int i = 0; i < 6; i++) src_q[2].push_back({32'b0, 32'h3000_0000 + 32'(4 * i)});
    repeat (5) cycle();
    chk("bp_accepted", 64'(hs_in_cnt[2] - base), 64'd2);
    chk("bp_s_arready", {63'b0, s_if.arready}, 64'd0);
    ready_pct[2] = 100;
    drain(100);
    chk("bp_emitted", 64'(hs_out_cnt[2] - obase), 64'd6);

    // Randomised traffic on all channels
    for (int i = 0; i < 400; i++) begin
      src_q[0].push_back({29'b0, 3'($urandom), 32'($urandom)});
      src_q[1].push_back({28'b0, 4'($urandom), 32'($urandom)});
      src_q[2].push_back({29'b0, 3'($urandom), 32'($urandom)});
    end
    for (int c = 0; c < 5; c++) begin
      valid_pct[c] = int'($urandom_range(40, 90));
      ready_pct[c] = int'($urandom_range(40, 90));
    end
    drain(20000);
    for (int c = 0; c < 5; c++) begin
      valid_pct[c] = 100;
      ready_pct[c] = 100;
    end

    // Reset with AR buffer full
    ready_pct[2] = 0;
    for (int i = 0; i < 4; i++) src_q[2].push_back({32'b0, 32'h4000_0000 + 32'(4 * i)});
    repeat (4) cycle();
    chk("full_s_arready", {63'b0, s_if.arready}, 64'd0);
    rst = 1'b1;
    clear_sources();
    cycle();
    chk("midrst_valids", {59'b0, m_if.awvalid, m_if.wvalid, m_if.arvalid, s_if.bvalid, s_if.rvalid}, 64'd0);
    chk("midrst_readies", {59'b0, s_if.awready, s_if.wready, s_if.arready, m_if.bready, m_if.rready}, 64'd0);
    rst = 1'b0;
    clear_sources();
    ready_pct[2] = 100;
    cycle();
    chk("after_rst_readies", {59'b0, s_if.awready, s_if.wready, s_if.arready, m_if.bready, m_if.rready}, 64'h1F);
`ifdef AXIL_SLICE_OUTSTANDING_EN
    chk("after_rst_rd_cnt", 64'(dut.rd_cnt_r), 64'd0);
    chk("after_rst_wr_cnt", 64'(dut.wr_cnt_r), 64'd0);

    // Outstanding limit: 6 ARs, R held off
    ready_pct[4] = 0;
    base = hs_out_cnt[2];
    for (int i = 0; i < 6; i++) src_q[2].push_back({32'b0, 32'h5000_0000 + 32'(4 * i)});
    repeat (15) cycle();
    chk("ost_issued", 64'(hs_out_cnt[2] - base), 64'd4);
    ready_pct[4] = 100;
    obase = hs_out_cnt[4];
    seen  = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      seen = (hs_out_cnt[4] > obase);
    end
    chk("ost_5th_valid", {63'b0, m_if.arvalid}, 64'd1);
    chk("ost_5th_addr", {32'b0, m_if.araddr}, 64'h5000_0010);
    drain(100);
    chk("ost_total", 64'(hs_out_cnt[2] - base), 64'd6);
`endif
    drain(50);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axi4lite_reg_slice.md
Name: axi4lite_reg_slice

Overview:
- Full-throughput AXI4-Lite register slice between the CPU controller master port and the interconnect master port.
- Breaks every combinational path on all five channels (AW, W, B, AR, R) to close timing on the CPU-to-fabric hop.
- Protocol-transparent: no reordering, merging or dropping; payloads pass unmodified.

Parameters:
- ADDR_WIDTH, 32, address width of AW/AR.
- DATA_WIDTH, 32, data width of W/R; strobe width is DATA_WIDTH/8.
- MAX_OUTSTANDING, 4, per-direction outstanding limit; used only with AXIL_SLICE_OUTSTANDING_EN; must be ≥1.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_awaddr/s_awprot/s_awvalid  in  ADDR_WIDTH/3/1  AW from CPU; s_awready out 1.
- s_wdata/s_wstrb/s_wvalid  in  DATA_WIDTH/DATA_WIDTH/8/1  W from CPU; s_wready out 1.
- s_bresp/s_bvalid  out  2/1  B to CPU; s_bready in 1.
- s_araddr/s_arprot/s_arvalid  in  ADDR_WIDTH/3/1  AR from CPU; s_arready out 1.
- s_rdata/s_rresp/s_rvalid  out  DATA_WIDTH/2/1  R to CPU; s_rready in 1.
- m_awaddr/m_awprot/m_awvalid  out  ADDR_WIDTH/3/1  AW to interconnect; m_awready in 1.
- m_wdata/m_wstrb/m_wvalid  out  DATA_WIDTH/DATA_WIDTH/8/1  W to interconnect; m_wready in 1.
- m_bresp/m_bvalid  in  2/1  B from interconnect; m_bready out 1.
- m_araddr/m_arprot/m_arvalid  out  ADDR_WIDTH/3/1  AR to interconnect; m_arready in 1.
- m_rdata/m_rresp/m_rvalid  in  DATA_WIDTH/2/1  R from interconnect; m_rready out 1.

Behaviour:
- Each channel is an independent 2-entry skid buffer: one main register and one skid register, each with a valid bit.
- Reset state:
  - All valid outputs are 0, all ready outputs are 0, and all payload outputs are 0.
  - First cycle after rst deasserts, every ready output is 1 (buffers empty).
- Forward direction (sender to receiver):
  - Output valid and payload come straight from the main register; there is no combinational in-to-out path.
  - Latency is exactly 1 cycle: a handshake at cycle N appears on the far side at N+1.
- Backward path:
  - Ready toward the sender is registered: ready = !skid_valid.
  - Ready never depends combinationally on the downstream ready.
- Channel states: EMPTY (main=0, skid=0), ONE (main=1, skid=0), FULL (main=1, skid=1).
  - EMPTY + in_hs → ONE.
  - ONE + in_hs + out_hs → ONE; main is loaded with the new beat.
  - ONE + in_hs + !out_hs → FULL; the beat goes to skid and ready drops next cycle.
  - ONE + out_hs + !in_hs → EMPTY.
  - FULL + out_hs → ONE; skid moves to main and ready rises next cycle.
  - FULL never accepts input.
- Throughput: a continuous stream with the receiver always ready sustains 1 beat/cycle.
- Backpressure: when the receiver stalls, the sender sees ready drop one cycle later; at most 2 beats are buffered and none is lost.
- Payload stability: output payload is stable while valid=1 and ready=0 (AXI rule). valid never deasserts without a handshake.
- AW/W independence: AW and W are not coupled; either may arrive first, and ordering within each channel is preserved.
- Reset mid-operation: rst empties all buffers in the same cycle, and in-flight beats are discarded. The integrator resets the CPU and interconnect together with the slice.

Optional Feature:
AXIL_SLICE_OUTSTANDING_EN
- Defined:
  - Read counter rd_cnt (width clog2(MAX_OUTSTANDING+1)): increments on the m_ar handshake, decrements on the s_r handshake; both in the same cycle leave it unchanged.
  - m_arvalid is gated low while rd_cnt == MAX_OUTSTANDING; the AR beat stays held in the buffer.
  - Write counter wr_cnt works the same way: increments on the m_aw handshake, decrements on the s_b handshake, and gates m_awvalid.
  - Both counters reset to 0.
  - Gating is applied before valid is presented. A valid is never withdrawn once asserted.
- Undefined: no counters and no gating; outstanding depth is unbounded.

Test Plan:
- Single write: s_aw 0x1000_0010, s_w 0xDEADBEEF strb 0xF, all readies high → m_awvalid and m_wvalid at cycle+1 with identical payload; m_bresp 0 returns as s_bresp 0 one cycle after the m_b handshake.
- Streaming reads: 16 back-to-back ARs 0x2000_0000+4i, m_arready=1 → 16 m_ar beats on consecutive cycles, in order, no bubbles.
- Backpressure: m_arready=0 for 5 cycles during an AR stream → s_arready drops after 2 accepted beats; on release all beats emerge in order, none duplicated or lost.
- Randomised ready/valid on all channels over 2000 beats → scoreboard shows matching payload order; payload stable while valid&&!ready.
- Reset mid-burst: assert rst with AR FULL → next cycle all valids 0, all readies 0; after deassert, readies 1 and counters 0.
- With AXIL_SLICE_OUTSTANDING_EN, MAX_OUTSTANDING=4, 6 ARs issued, R held off → exactly 4 m_ar handshakes; the 5th issues the cycle after the first s_r handshake.
